b2to1_bus_arbiter: RTL and testbench



---
 rtl/b2to1_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_b2to1_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/b2to1_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : b2to1_bus_arbiter
// Description : Two-requester arbiter and tristate bus driver. Grants one of
//               two 4-phase req/ack sources, latches the winner's word,
//               drives it onto a shared bus under a valid/ready handshake and
//               presents the winner as the downstream muxer select (b0).
//               Optional macro ROUND_ROBIN_EN: alternate winners on a tie
//               (the first tie after reset goes to source 0). Without it,
//               source 0 always wins a tie.
// Ports       : clock      - system clock, rising edge
//               reset_     - asynchronous reset, active low
//               req1_req0  - 4-phase requests from source 1 / source 0
//               ack1_ack0  - acknowledges to source 1 / source 0
//               d0, d1     - source words, stable while their req is high
//               b0         - select of the current winner (0 = src 0)
//               bus        - shared tristate bus, driven only in DRIVE
//               valid      - bus holds a valid word
//               ready      - consumer accepts the word
// Revision    : 1.0 - initial release
// ============================================================================
module b2to1_bus_arbiter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic [1:0]   req1_req0,
    output logic [1:0]   ack1_ack0,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic         b0,
    inout  wire  [W-1:0] bus,
    output logic         valid,
    input  logic         ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t       r_star;
    state_t       w_star_nxt;
    logic [W-1:0] r_word;
    logic [W-1:0] w_word_nxt;
    logic         r_b0;
    logic         w_b0_nxt;
    logic [1:0]   r_ack;
    logic [1:0]   w_ack_nxt;
    logic         r_last;
    logic         w_last_nxt;
    logic         w_tie_winner;
    logic         w_winner;

`ifdef ROUND_ROBIN_EN
    // r_last resets to 1, so the first tie after reset goes to source 0.
    assign w_tie_winner = ~r_last;
`else
    assign w_tie_winner = 1'b0;
`endif

    // With a single request, bit 1 of the request vector names the requester.
    assign w_winner = (req1_req0 == 2'b11) ? w_tie_winner : req1_req0[1];

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_star <= ST_IDLE;
            r_word <= '0;
            r_b0   <= 1'b0;
            r_ack  <= 2'b00;
            r_last <= 1'b1;
        end else begin
            r_star <= w_star_nxt;
            r_word <= w_word_nxt;
            r_b0   <= w_b0_nxt;
            r_ack  <= w_ack_nxt;
            r_last <= w_last_nxt;
        end
    end

    always_comb begin
        w_star_nxt = r_star;
        w_word_nxt = r_word;
        w_b0_nxt   = r_b0;
        w_ack_nxt  = r_ack;
        w_last_nxt = r_last;
        case (r_star)
            ST_IDLE: begin
                if (req1_req0 != 2'b00) begin
                    w_word_nxt = w_winner ? d1 : d0;
                    w_b0_nxt   = w_winner;
                    w_star_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                // A dropped req during DRIVE is deliberately ignored; the
                // latched word is still delivered.
                if (ready) begin
                    w_ack_nxt  = r_b0 ? 2'b10 : 2'b01;
                    w_star_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!req1_req0[r_b0]) begin
                    w_ack_nxt  = 2'b00;
                    w_last_nxt = r_b0;
                    w_star_nxt = ST_IDLE;
                end
            end
            default: begin
                w_star_nxt = ST_IDLE;
            end
        endcase
    end

    // valid and the bus enable decode straight from the state register so an
    // asynchronous reset releases the bus in the same cycle.
    assign valid     = (r_star == ST_DRIVE);
    assign bus       = valid ? r_word : {W{1'bz}};
    assign b0        = r_b0;
    assign ack1_ack0 = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_b2to1_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_b2to1_bus_arbiter
// Description : Self-checking bench for b2to1_bus_arbiter. A transaction-level
//               model predicts valid/b0/ack/bus every cycle; directed tests
//               add literal expectations. Build with or without
//               ROUND_ROBIN_EN to match the DUT build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_b2to1_bus_arbiter;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset_ = 1'b0;
    logic [1:0]   req1_req0 = 2'b00;
    logic [W-1:0] d0 = '0;
    logic [W-1:0] d1 = '0;
    logic         ready = 1'b0;
    wire  [1:0]   ack1_ack0;
    wire          b0;
    wire          valid;
    wire  [W-1:0] bus;

    int n_checks = 0;
    int n_errors = 0;

    b2to1_bus_arbiter #(.W(W)) u_dut (
        .clock     (clock),
        .reset_    (reset_),
        .req1_req0 (req1_req0),
        .ack1_ack0 (ack1_ack0),
        .d0        (d0),
        .d1        (d1),
        .b0        (b0),
        .bus       (bus),
        .valid     (valid),
        .ready     (ready)
    );

    always #5 clock = ~clock;

    // A released bus reads as Z on a 4-state simulator and as 0 on a
    // 2-state one; every test word is nonzero, so a driven bus is visible.
    function automatic bit released(input logic [W-1:0] v);
        return ($isunknown(v) || (v == '0));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_z(input string name);
        n_checks++;
        if (!released(bus)) begin
            n_errors++;
            $display("FAIL %s: bus=%h expected Z at %0t", name, bus, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // ---------------- transaction-level model ----------------
    bit           m_busy;   // a transfer has been granted and not finished
    bit           m_done;   // consumer has taken the word; waiting for req drop
    bit           m_who;
    bit           m_last;
    logic [W-1:0] m_word;

    always @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_who  = 1'b0;
            m_last = 1'b1;
            m_word = '0;
        end else if (!m_busy) begin
            if (req1_req0 != 2'b00) begin
                if (req1_req0 == 2'b01)      m_who = 1'b0;
                else if (req1_req0 == 2'b10) m_who = 1'b1;
                else begin
`ifdef ROUND_ROBIN_EN
                    m_who = !m_last;
`else
                    m_who = 1'b0;
`endif
                end
                m_word = m_who ? d1 : d0;
                m_busy = 1'b1;
                m_done = 1'b0;
            end
        end else if (!m_done) begin
            if (ready) m_done = 1'b1;
        end else if (!req1_req0[m_who]) begin
            m_busy = 1'b0;
            m_last = m_who;
        end
    end

    always @(negedge clock) begin
        bit ev;
        ev = m_busy && !m_done;
        chk("model_valid", {31'd0, valid}, {31'd0, ev});
        chk("model_b0", {31'd0, b0}, {31'd0, m_who});
        chk("model_ack", {30'd0, ack1_ack0},
            (m_busy && m_done) ? (m_who ? 32'd2 : 32'd1) : 32'd0);
        if (ev) chk("model_bus", {24'd0, bus}, {24'd0, m_word});
        else    chk_z("model_bus_z");
    end

    // ---------------- directed stimulus ----------------
    logic [3:0] exp_seq;
    bit         got;

    initial begin
`ifdef ROUND_ROBIN_EN
        exp_seq = 4'b1010;
`else
        exp_seq = 4'b0000;
`endif
        // Reset held with both requests pending.
        reset_ = 1'b0; req1_req0 = 2'b11; d0 = 8'h11; d1 = 8'h22; ready = 1'b0;
        repeat (3) tick();
        chk("rst_ack", {30'd0, ack1_ack0}, 32'd0);
        chk("rst_b0", {31'd0, b0}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk_z("rst_bus");
        reset_ = 1'b1;
        tick();
        chk("rel_b0", {31'd0, b0}, 32'd0);
        chk("rel_valid", {31'd0, valid}, 32'd1);
        chk("rel_bus", {24'd0, bus}, 32'h11);
        ready = 1'b1;
        tick();
        chk("rel_ack0", {30'd0, ack1_ack0}, 32'd1);
        req1_req0 = 2'b10;
        tick();
        chk("rel_ack_clr", {30'd0, ack1_ack0}, 32'd0);
        tick();
        chk("loser_b0", {31'd0, b0}, 32'd1);
        chk("loser_bus", {24'd0, bus}, 32'h22);
        tick();
        chk("loser_ack", {30'd0, ack1_ack0}, 32'd2);
        req1_req0 = 2'b00;
        tick();

        // Single transfer from source 0.
        d0 = 8'hA5; req1_req0 = 2'b01; ready = 1'b1;
        tick();
        chk("single_b0", {31'd0, b0}, 32'd0);
        chk("single_bus", {24'd0, bus}, 32'hA5);
        chk("single_valid", {31'd0, valid}, 32'd1);
        tick();
        chk("single_ack", {30'd0, ack1_ack0}, 32'd1);
        chk_z("single_bus_z");
        req1_req0 = 2'b00;
        tick();
        chk("single_ack_clr", {30'd0, ack1_ack0}, 32'd0);

        // Backpressure on source 1.
        d1 = 8'h3C; req1_req0 = 2'b10; ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_bus", {24'd0, bus}, 32'h3C);
            chk("bp_valid", {31'd0, valid}, 32'd1);
            chk("bp_b0", {31'd0, b0}, 32'd1);
            chk("bp_noack", {30'd0, ack1_ack0}, 32'd0);
            tick();
        end
        ready = 1'b1;
        tick();
        chk("bp_ack1", {30'd0, ack1_ack0}, 32'd2);
        req1_req0 = 2'b00; ready = 1'b0;
        tick();

        // Continuous contention.
        d0 = 8'h5A; d1 = 8'h69; req1_req0 = 2'b11; ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int n;
            n = 0;
            do begin
                tick();
                n++;
            end while (!valid && n < 10);
            chk("cont_grant", {31'd0, valid}, 32'd1);
            got = b0;
            chk($sformatf("cont_b0_%0d", k), {31'd0, b0}, {31'd0, exp_seq[k]});
            tick();
            chk("cont_ack", {30'd0, ack1_ack0}, got ? 32'd2 : 32'd1);
            req1_req0[got] = 1'b0;
            tick();
            chk("cont_ack_clr", {30'd0, ack1_ack0}, 32'd0);
            req1_req0[got] = 1'b1;
        end
        req1_req0 = 2'b00; ready = 1'b0;
        tick();

        // Reset in the middle of DRIVE.
        d0 = 8'h5A; req1_req0 = 2'b01; ready = 1'b0;
        tick();
        chk("mid_valid_pre", {31'd0, valid}, 32'd1);
        #1;
        reset_ = 1'b0; req1_req0 = 2'b00;
        #1;
        chk("mid_valid", {31'd0, valid}, 32'd0);
        chk("mid_ack", {30'd0, ack1_ack0}, 32'd0);
        chk("mid_b0", {31'd0, b0}, 32'd0);
        chk_z("mid_bus");
        tick();
        reset_ = 1'b1;
        tick();

        // Request dropped during DRIVE.
        d0 = 8'hC3; req1_req0 = 2'b01; ready = 1'b0;
        tick();
        req1_req0 = 2'b00;
        tick();
        chk("early_valid", {31'd0, valid}, 32'd1);
        chk("early_bus", {24'd0, bus}, 32'hC3);
        ready = 1'b1;
        tick();
        chk("early_ack", {30'd0, ack1_ack0}, 32'd1);
        chk("early_valid_clr", {31'd0, valid}, 32'd0);
        tick();
        chk("early_ack_clr", {30'd0, ack1_ack0}, 32'd0);
        tick();
        chk("early_idle", {31'd0, valid}, 32'd0);
        ready = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
